// File: rtl/core2_cpu_0_oci_dct_packer.sv
// DCT atom packer: shifts retired direct-transfer atoms into a live buffer,
// hands full/flushed buffers out as frames (valid/ready) and sequences the
// end-of-test indications once the trace path has drained.
//
// Ports:
//   clk_i, reset_i        rising-edge clock, synchronous active-high reset
//   dct_valid_i/code_i    one atom per cycle
//   flush_i               emit the partial buffer
//   test_stop_i           drain and end the test
//   frame_ready_i         consumer accepts frame
//   frame_valid_o/data_o/count_o   frame register
//   dct_buffer_o/count_o  live packing buffer
//   overflow_o            sticky atom-dropped flag
//   test_ending_o         one-cycle pulse when drained
//   test_has_ended_o      sticky after test_ending_o
module core2_cpu_0_oci_dct_packer #(
  parameter int ATOMS  = 15,
  parameter int ATOM_W = 2,
  localparam int BUF_W = ATOMS * ATOM_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              dct_valid_i,
  input  logic [ATOM_W-1:0] dct_code_i,
  input  logic              flush_i,
  input  logic              test_stop_i,
  input  logic              frame_ready_i,
  output logic              frame_valid_o,
  output logic [BUF_W-1:0]  frame_data_o,
  output logic [3:0]        frame_count_o,
  output logic [BUF_W-1:0]  dct_buffer_o,
  output logic [3:0]        dct_count_o,
  output logic              overflow_o,
  output logic              test_ending_o,
  output logic              test_has_ended_o
);

  localparam logic [3:0] FULL = 4'(ATOMS);

  typedef enum logic [1:0] {
    S_RUN,
    S_DRAIN,
    S_ENDING,
    S_ENDED
  } state_e;

  state_e           state_q, state_d;
  logic [BUF_W-1:0] buf_q, buf_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             fv_q, fv_d;
  logic [BUF_W-1:0] fdata_q, fdata_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic             ovf_q, ovf_d;
  logic             fp_q, fp_d;
  logic             ending_q, ending_d;
  logic             ended_q, ended_d;

  logic slot_free;
  logic active;
  logic run;
  logic fp_eff;
  logic full;
  logic emit;
  logic take;
  logic drop;

  always_comb begin
    slot_free = !fv_q || frame_ready_i;
    run       = (state_q == S_RUN);
    active    = run || (state_q == S_DRAIN);
    // Draining behaves like a permanent flush request.
    fp_eff    = fp_q || (state_q == S_DRAIN);
    full      = (cnt_q == FULL);
    emit      = active && slot_free
              && (full || (fp_eff && cnt_q != 4'd0));
    // A full buffer only takes a new atom if it empties this cycle.
    take      = run && dct_valid_i && (!full || emit);
    drop      = run && dct_valid_i && full && !slot_free;

    buf_d    = buf_q;
    cnt_d    = cnt_q;
    fv_d     = fv_q;
    fdata_d  = fdata_q;
    fcnt_d   = fcnt_q;
    ovf_d    = ovf_q;
    fp_d     = fp_q;
    state_d  = state_q;
    ending_d = 1'b0;
    ended_d  = ended_q;

    if (emit) begin
      fdata_d = buf_q;
      fcnt_d  = cnt_q;
      fv_d    = 1'b1;
      buf_d   = '0;
      cnt_d   = 4'd0;
    end else if (fv_q && frame_ready_i) begin
      fv_d = 1'b0;
    end

    if (take) begin
      if (emit) begin
        buf_d = BUF_W'(dct_code_i);
        cnt_d = 4'd1;
      end else begin
        buf_d = (buf_q << ATOM_W) | BUF_W'(dct_code_i);
        cnt_d = cnt_q + 4'd1;
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
    end

    // A new flush wins over clearing, so an atom that arrives with a
    // full-buffer emit still gets flushed on the following cycle.
    if (flush_i && active) begin
      fp_d = 1'b1;
    end else if (emit || cnt_q == 4'd0) begin
      fp_d = 1'b0;
    end

    unique case (state_q)
      S_RUN: begin
        if (test_stop_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (cnt_q == 4'd0 && !fv_q) begin
          state_d  = S_ENDING;
          ending_d = 1'b1;
        end
      end
      S_ENDING: begin
        state_d = S_ENDED;
        ended_d = 1'b1;
      end
      default: begin
        state_d = S_ENDED;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_RUN;
      buf_q    <= '0;
      cnt_q    <= 4'd0;
      fv_q     <= 1'b0;
      fdata_q  <= '0;
      fcnt_q   <= 4'd0;
      ovf_q    <= 1'b0;
      fp_q     <= 1'b0;
      ending_q <= 1'b0;
      ended_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      buf_q    <= buf_d;
      cnt_q    <= cnt_d;
      fv_q     <= fv_d;
      fdata_q  <= fdata_d;
      fcnt_q   <= fcnt_d;
      ovf_q    <= ovf_d;
      fp_q     <= fp_d;
      ending_q <= ending_d;
      ended_q  <= ended_d;
    end
  end

  assign frame_valid_o    = fv_q;
  assign frame_data_o     = fdata_q;
  assign frame_count_o    = fcnt_q;
  assign dct_buffer_o     = buf_q;
  assign dct_count_o      = cnt_q;
  assign overflow_o       = ovf_q;
  assign test_ending_o    = ending_q;
  assign test_has_ended_o = ended_q;

endmodule

// File: tb/tb_core2_cpu_0_oci_dct_packer.sv
// Self-checking bench for the DCT packer: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_core2_cpu_0_oci_dct_packer;

  localparam int ATOMS = 15;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        dct_valid_i = 1'b0;
  logic [1:0]  dct_code_i = 2'd0;
  logic        flush_i = 1'b0;
  logic        test_stop_i = 1'b0;
  logic        frame_ready_i = 1'b0;
  logic        frame_valid_o;
  logic [29:0] frame_data_o;
  logic [3:0]  frame_count_o;
  logic [29:0] dct_buffer_o;
  logic [3:0]  dct_count_o;
  logic        overflow_o;
  logic        test_ending_o;
  logic        test_has_ended_o;

  int tests = 0;
  int fails = 0;

  // Reference model: atoms held as queues, states by name order
  // 0 run, 1 drain, 2 ending, 3 ended.
  int m_q[$];
  int m_f[$];
  bit m_fv, m_fp, m_ovf;
  int m_st;

  always #5 clk_i = ~clk_i;

  core2_cpu_0_oci_dct_packer dut (
    .clk_i           (clk_i),
    .reset_i         (reset_i),
    .dct_valid_i     (dct_valid_i),
    .dct_code_i      (dct_code_i),
    .flush_i         (flush_i),
    .test_stop_i     (test_stop_i),
    .frame_ready_i   (frame_ready_i),
    .frame_valid_o   (frame_valid_o),
    .frame_data_o    (frame_data_o),
    .frame_count_o   (frame_count_o),
    .dct_buffer_o    (dct_buffer_o),
    .dct_count_o     (dct_count_o),
    .overflow_o      (overflow_o),
    .test_ending_o   (test_ending_o),
    .test_has_ended_o(test_has_ended_o)
  );

  function automatic logic [29:0] pack(input int a[$]);
    logic [29:0] r = '0;
    foreach (a[i]) r = (r << 2) | 30'(a[i]);
    return r;
  endfunction

  task automatic tick(input bit rst, input bit v, input int c,
                      input bit fl, input bit ts, input bit rdy);
    int  n, st_n;
    bit  slot, act, emit;
    reset_i = rst;
    dct_valid_i = v;
    dct_code_i = 2'(c);
    flush_i = fl;
    test_stop_i = ts;
    frame_ready_i = rdy;
    @(posedge clk_i);
    if (rst) begin
      m_q.delete();
      m_f.delete();
      m_fv = 0; m_fp = 0; m_ovf = 0; m_st = 0;
    end else begin
      n = m_q.size();
      slot = !m_fv || rdy;
      act = (m_st < 2);
      emit = act && slot &&
             (n == ATOMS || ((m_fp || m_st == 1) && n != 0));
      st_n = m_st;
      if (m_st == 0 && ts) st_n = 1;
      else if (m_st == 1 && n == 0 && !m_fv) st_n = 2;
      else if (m_st >= 2) st_n = 3;
      if (emit) begin
        m_f = m_q;
        m_fv = 1;
        m_q.delete();
      end else if (m_fv && rdy) begin
        m_fv = 0;
      end
      if (m_st == 0 && v) begin
        if (emit || n < ATOMS) m_q.push_back(c & 3);
        else m_ovf = 1;
      end
      if (fl && act) m_fp = 1;
      else if (emit || n == 0) m_fp = 0;
      m_st = st_n;
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, 0, 0, 0, 0);
    tests += 8;
    if (frame_valid_o !== 1'b0) begin
      fails++; $display("FAIL reset_fv got %0b want 0", frame_valid_o);
    end
    if (frame_data_o !== 30'd0) begin
      fails++; $display("FAIL reset_fdata got %h want 0", frame_data_o);
    end
    if (frame_count_o !== 4'd0) begin
      fails++; $display("FAIL reset_fcnt got %0d want 0", frame_count_o);
    end
    if (dct_buffer_o !== 30'd0) begin
      fails++; $display("FAIL reset_buf got %h want 0", dct_buffer_o);
    end
    if (dct_count_o !== 4'd0) begin
      fails++; $display("FAIL reset_cnt got %0d want 0", dct_count_o);
    end
    if (overflow_o !== 1'b0) begin
      fails++; $display("FAIL reset_ovf got %0b want 0", overflow_o);
    end
    if (test_ending_o !== 1'b0) begin
      fails++; $display("FAIL reset_end got %0b want 0", test_ending_o);
    end
    if (test_has_ended_o !== 1'b0) begin
      fails++; $display("FAIL reset_ended got %0b want 0", test_has_ended_o);
    end
  endtask

  task automatic test_full_frame();
    tick(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 15; i++) tick(0, 1, 1, 0, 0, 1);
    tests += 2;
    if (dct_count_o !== 4'd15) begin
      fails++; $display("FAIL full_cnt got %0d want 15", dct_count_o);
    end
    if (frame_valid_o !== 1'b0) begin
      fails++; $display("FAIL full_early got %0b want 0", frame_valid_o);
    end
    tick(0, 0, 0, 0, 0, 1);
    tests += 4;
    if (frame_valid_o !== 1'b1) begin
      fails++; $display("FAIL full_fv got %0b want 1", frame_valid_o);
    end
    if (frame_data_o !== 30'h15555555) begin
      fails++;
      $display("FAIL full_data got %h want 15555555", frame_data_o);
    end
    if (frame_count_o !== 4'd15) begin
      fails++; $display("FAIL full_fcnt got %0d want 15", frame_count_o);
    end
    if (dct_count_o !== 4'd0) begin
      fails++; $display("FAIL full_clr got %0d want 0", dct_count_o);
    end
  endtask

  task automatic test_flush();
    tick(1, 0, 0, 0, 0, 1);
    tick(0, 1, 3, 0, 0, 1);
    tick(0, 1, 2, 0, 0, 1);
    tick(0, 1, 1, 0, 0, 1);
    tick(0, 0, 0, 1, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tests += 3;
    if (frame_valid_o !== 1'b1) begin
      fails++; $display("FAIL flush_fv got %0b want 1", frame_valid_o);
    end
    if (frame_data_o !== 30'h39) begin
      fails++; $display("FAIL flush_data got %h want 39", frame_data_o);
    end
    if (frame_count_o !== 4'd3) begin
      fails++; $display("FAIL flush_fcnt got %0d want 3", frame_count_o);
    end
    tick(0, 0, 0, 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 0, 1);
      tests++;
      if (frame_valid_o !== 1'b0) begin
        fails++; $display("FAIL flush_empty got %0b want 0", frame_valid_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a[$];
    int f1[$];
    int f2[$];
    logic [29:0] e1, e2;
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 31; i++) a.push_back(int'($urandom_range(0, 3)));
    for (int i = 0; i < 15; i++) f1.push_back(a[i]);
    for (int i = 15; i < 30; i++) f2.push_back(a[i]);
    e1 = pack(f1);
    e2 = pack(f2);
    for (int i = 0; i < 31; i++) begin
      tick(0, 1, a[i], 0, 0, 0);
      tests++;
      if (i >= 15) begin
        if (frame_valid_o !== 1'b1 || frame_data_o !== e1) begin
          fails++;
          $display("FAIL bp_hold%0d got %0b/%h want 1/%h",
                   i, frame_valid_o, frame_data_o, e1);
        end
      end else if (frame_valid_o !== 1'b0) begin
        fails++; $display("FAIL bp_idle%0d got %0b want 0", i, frame_valid_o);
      end
      if (i == 29 || i == 30) begin
        tests++;
        if (overflow_o !== (i == 30)) begin
          fails++;
          $display("FAIL bp_ovf%0d got %0b want %0b", i, overflow_o, i == 30);
        end
      end
    end
    tests += 2;
    if (dct_count_o !== 4'd15) begin
      fails++; $display("FAIL bp_cnt got %0d want 15", dct_count_o);
    end
    if (dct_buffer_o !== e2) begin
      fails++; $display("FAIL bp_buf got %h want %h", dct_buffer_o, e2);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0, 0);
      tests++;
      if (overflow_o !== 1'b1 || frame_data_o !== e1) begin
        fails++;
        $display("FAIL bp_stable got %0b/%h want 1/%h",
                 overflow_o, frame_data_o, e1);
      end
    end
    tick(0, 0, 0, 0, 0, 1);
    tests += 3;
    if (frame_valid_o !== 1'b1 || frame_data_o !== e2) begin
      fails++;
      $display("FAIL bp_second got %0b/%h want 1/%h",
               frame_valid_o, frame_data_o, e2);
    end
    if (frame_count_o !== 4'd15) begin
      fails++; $display("FAIL bp_fcnt got %0d want 15", frame_count_o);
    end
    if (dct_count_o !== 4'd0) begin
      fails++; $display("FAIL bp_empty got %0d want 0", dct_count_o);
    end
    tick(0, 0, 0, 0, 0, 1);
    tests += 2;
    if (frame_valid_o !== 1'b0) begin
      fails++; $display("FAIL bp_done got %0b want 0", frame_valid_o);
    end
    if (overflow_o !== 1'b1) begin
      fails++; $display("FAIL bp_sticky got %0b want 1", overflow_o);
    end
  endtask

  task automatic test_flush_with_atom();
    tick(1, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) tick(0, 1, 2, 0, 0, 1);
    tick(0, 1, 3, 1, 0, 1);
    tests++;
    if (dct_count_o !== 4'd5) begin
      fails++; $display("FAIL fa_cnt got %0d want 5", dct_count_o);
    end
    tick(0, 0, 0, 0, 0, 1);
    tests += 2;
    if (frame_valid_o !== 1'b1 || frame_count_o !== 4'd5) begin
      fails++;
      $display("FAIL fa_frame got %0b/%0d want 1/5",
               frame_valid_o, frame_count_o);
    end
    if (frame_data_o !== 30'h2ab) begin
      fails++; $display("FAIL fa_data got %h want 2ab", frame_data_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0, 0, 0, 1);
      tests++;
      if (frame_valid_o !== 1'b0) begin
        fails++; $display("FAIL fa_single got %0b want 0", frame_valid_o);
      end
    end
  endtask

  task automatic test_drain();
    tick(1, 0, 0, 0, 0, 1);
    tick(0, 1, 1, 0, 0, 1);
    tick(0, 1, 2, 0, 0, 1);
    tick(0, 0, 0, 0, 1, 1);
    tick(0, 1, 3, 0, 0, 1);
    tests += 2;
    if (frame_valid_o !== 1'b1 || frame_count_o !== 4'd2) begin
      fails++;
      $display("FAIL dr_frame got %0b/%0d want 1/2",
               frame_valid_o, frame_count_o);
    end
    if (dct_count_o !== 4'd0 || frame_data_o !== 30'h6) begin
      fails++;
      $display("FAIL dr_data got %0d/%h want 0/6", dct_count_o, frame_data_o);
    end
    tick(0, 1, 3, 0, 0, 1);
    tests += 2;
    if (frame_valid_o !== 1'b0 || dct_count_o !== 4'd0) begin
      fails++;
      $display("FAIL dr_ignore got %0b/%0d want 0/0",
               frame_valid_o, dct_count_o);
    end
    if (test_ending_o !== 1'b0) begin
      fails++; $display("FAIL dr_early got %0b want 0", test_ending_o);
    end
    tick(0, 1, 1, 0, 0, 1);
    tests++;
    if (test_ending_o !== 1'b1 || test_has_ended_o !== 1'b0) begin
      fails++;
      $display("FAIL dr_pulse got %0b/%0b want 1/0",
               test_ending_o, test_has_ended_o);
    end
    for (int i = 0; i < 4; i++) begin
      tick(0, 1, 2, 1, 1, 1);
      tests++;
      if (test_ending_o !== 1'b0 || test_has_ended_o !== 1'b1 ||
          dct_count_o !== 4'd0 || frame_valid_o !== 1'b0) begin
        fails++;
        $display("FAIL dr_ended got %0b/%0b/%0d/%0b want 0/1/0/0",
                 test_ending_o, test_has_ended_o,
                 dct_count_o, frame_valid_o);
      end
    end
    tick(1, 0, 0, 0, 0, 1);
    tests++;
    if (test_has_ended_o !== 1'b0) begin
      fails++; $display("FAIL dr_reset got %0b want 0", test_has_ended_o);
    end
  endtask

  task automatic test_reset_midflight();
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 22; i++) tick(0, 1, 3, 0, 0, 0);
    tests++;
    if (frame_valid_o !== 1'b1 || dct_count_o !== 4'd7) begin
      fails++;
      $display("FAIL mf_setup got %0b/%0d want 1/7",
               frame_valid_o, dct_count_o);
    end
    tick(1, 1, 3, 1, 0, 0);
    tests++;
    if (frame_valid_o !== 1'b0 || frame_data_o !== 30'd0 ||
        frame_count_o !== 4'd0 || dct_buffer_o !== 30'd0 ||
        dct_count_o !== 4'd0 || overflow_o !== 1'b0 ||
        test_ending_o !== 1'b0 || test_has_ended_o !== 1'b0) begin
      fails++;
      $display("FAIL mf_reset got %0b/%h/%0d/%h/%0d/%0b/%0b/%0b want zeros",
               frame_valid_o, frame_data_o, frame_count_o, dct_buffer_o,
               dct_count_o, overflow_o, test_ending_o, test_has_ended_o);
    end
  endtask

  task automatic test_random();
    bit rst, v, fl, ts, rdy;
    int c;
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      v   = ($urandom_range(0, 9) < 7);
      c   = int'($urandom_range(0, 3));
      fl  = ($urandom_range(0, 19) == 0);
      ts  = ($urandom_range(0, 299) == 0);
      rdy = ($urandom_range(0, 9) < 6);
      tick(rst, v, c, fl, ts, rdy);
      tests++;
      if (frame_valid_o !== m_fv || dct_count_o !== 4'(m_q.size()) ||
          dct_buffer_o !== pack(m_q)) begin
        fails++;
        $display("FAIL rnd_buf@%0d got %0b/%0d/%h want %0b/%0d/%h", i,
                 frame_valid_o, dct_count_o, dct_buffer_o,
                 m_fv, m_q.size(), pack(m_q));
      end
      tests++;
      if (overflow_o !== m_ovf || test_ending_o !== (m_st == 2) ||
          test_has_ended_o !== (m_st == 3)) begin
        fails++;
        $display("FAIL rnd_flags@%0d got %0b/%0b/%0b want %0b/%0b/%0b", i,
                 overflow_o, test_ending_o, test_has_ended_o,
                 m_ovf, m_st == 2, m_st == 3);
      end
      if (m_fv) begin
        tests++;
        if (frame_data_o !== pack(m_f) ||
            frame_count_o !== 4'(m_f.size())) begin
          fails++;
          $display("FAIL rnd_frame@%0d got %h/%0d want %h/%0d", i,
                   frame_data_o, frame_count_o, pack(m_f), m_f.size());
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_flush();
    test_back_to_back();
    test_flush_with_atom();
    test_drain();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/core2_cpu_0_oci_dct_packer.md
Name: core2_cpu_0_oci_dct_packer

Overview:
- Upstream producer for the OCI trace test bench.
- Packs retired direct-control-transfer (DCT) atoms into a shift buffer and exposes the live buffer (dct_buffer, dct_count).
- Hands full or flushed buffers to the trace path as frames over a valid/ready handshake.
- Sequences the end-of-test indications (test_ending, test_has_ended) once tracing is drained.

Parameters:
- ATOMS, 15, atoms per frame; legal range 1..15.
- ATOM_W, 2, bits per atom.
- BUF_W, ATOMS*ATOM_W (30), buffer and frame width; derived, not overridden.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  synchronous reset, active-high.
- dct_valid  in  1  one DCT atom presented this cycle.
- dct_code  in  ATOM_W  atom value.
- flush  in  1  single-cycle request to emit the partial buffer (indirect transfer or trace stop).
- test_stop  in  1  single-cycle request to drain and end the test.
- frame_ready  in  1  consumer accepts the frame.
- frame_valid  out  1  frame register holds a frame.
- frame_data  out  BUF_W  packed atoms; oldest atom in the highest occupied bits.
- frame_count  out  4  number of atoms in frame_data.
- dct_buffer  out  BUF_W  live packing buffer.
- dct_count  out  4  atoms currently in dct_buffer.
- overflow  out  1  sticky: an atom was dropped.
- test_ending  out  1  single-cycle pulse when drain completes.
- test_has_ended  out  1  sticky after test_ending.

Behaviour:
- Reset: all outputs 0; buffer, frame register, flush_pending and state cleared. A frame in flight is discarded. Reset has priority over every other input.
- Slot free (slot_free) when frame_valid==0 OR frame_ready==1. A frame transfers on any cycle with frame_valid && frame_ready.
- Accept: in RUN, dct_valid with dct_count<ATOMS updates dct_buffer <= {dct_buffer[BUF_W-ATOM_W-1:0], dct_code} and dct_count+1.
- Emit condition: (dct_count==ATOMS OR (flush_pending && dct_count!=0)) && slot_free.
- On emit:
  - frame_data <= dct_buffer; frame_count <= dct_count; frame_valid <= 1.
  - Buffer is cleared to 0 and count to 0.
  - If dct_valid is high in the same cycle, the new atom becomes the sole content (count=1, buffer={0,dct_code}).
- Latency: frame_valid rises on the edge after the edge that made dct_count==ATOMS, provided slot_free.
- Buffer full (dct_count==ATOMS) with the slot not free and dct_valid high: atom dropped, overflow <= 1, buffer unchanged.
- Frame pending with no frame_ready: frame_valid and frame_data are held stable.
- Frame accepted with no new emit: frame_valid <= 0.
- Partial frames: bits above ATOM_W*count are 0.
- flush sets flush_pending. flush_pending clears on an emit caused by it, or when dct_count==0 (no empty frame is ever emitted).
- flush together with dct_valid: the atom is included in the flushed frame (the emit happens on a following cycle).
- If a full-buffer emit and flush coincide with dct_valid, the full buffer emits first; flush_pending stays set and the 1-atom buffer emits next.
- FSM:
  - RUN→DRAIN on test_stop.
  - DRAIN: dct_valid ignored (dropped, overflow unaffected); flush_pending forced 1.
  - DRAIN→ENDING when dct_count==0 && frame_valid==0.
  - ENDING: test_ending=1 for exactly one cycle, then →ENDED.
  - ENDED: test_has_ended=1, all inputs except reset ignored, held until reset.
  - test_stop outside RUN is ignored.
- Counters never wrap: dct_count saturates at ATOMS.

Test Plan:
- Reset then 15 consecutive dct_valid with dct_code=2'b01, frame_ready=1:
  - dct_count reaches 15.
  - Next edge: frame_valid=1, frame_data=30'h15555555, frame_count=15.
  - dct_count=0.
- 3 atoms (11,10,01) then flush: frame_data=30'h39 (6'b111001), frame_count=3, no frame emitted after a second flush with an empty buffer.
- frame_ready=0, 31 atoms:
  - First frame held stable.
  - Second buffer fills to 15.
  - 31st atom dropped; overflow=1 and stays 1.
  - Raising frame_ready drains both frames in order.
- flush and dct_valid same cycle with dct_count=4: the single emitted frame has frame_count=5.
- 2 atoms, test_stop, frame_ready=1:
  - Atoms during DRAIN ignored.
  - Frame count=2 emitted.
  - test_ending pulses one cycle after the frame is accepted, then test_has_ended=1 held.
- Reset asserted while frame_valid=1 and dct_count=7: the next cycle shows all outputs 0, and test_has_ended is cleared if it was set.
